data_in_window: RTL and testbench

- Parametrised sliding-window buffer on the memory read-data path.
- Presents the current input word plus the previous DEPTH-1 accepted words as parallel taps, so the decode stage sees a full operand window (e.g. A, B, C of a subleq instruction) at once.
- Adds what the fixed 3-tap delay line lacks: shift enable, per-tap valid tracking, flush, fill count and window-complete flag.
- Sits between memory data_in and instruction decode.

---
 rtl/data_in_window_pkg.sv | 23 ++
 rtl/data_in_window_stage.sv | 45 ++++
 rtl/data_in_window.sv | 130 +++++++++++++
 tb/tb_data_in_window.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_in_window_pkg.sv
// Shared definitions for the data_in_window sliding operand window.
// Build option: DATA_IN_WINDOW_ZERO_INVALID_EN (see data_in_window.sv).
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package data_in_window_pkg;

  // Default word width and legal window depth bounds.
  localparam int WORD_SIZE_DEF = `WORD_SIZE;
  localparam int DEPTH_DEF     = 3;
  localparam int DEPTH_MIN     = 2;
  localparam int DEPTH_MAX     = 16;

  // fill_count width for the default depth.
  localparam int FILL_W_DEF = $clog2(DEPTH_DEF);

  // Width of the fill counter for a given number of taps (counts 0..depth-1).
  function automatic int fill_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_in_window_stage.sv
// One registered stage of the operand window: a data word plus its valid bit.
// clear_i drops the valid bit only; the data word is kept as it was.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module data_in_window_stage
  import data_in_window_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic                 valid_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 valid_o
);

  logic [WORD_SIZE-1:0] data_q;
  logic                 valid_q;

  // Stage register: reset wins, then clear (valid only), then load, else hold.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      data_q  <= {WORD_SIZE{1'b0}};
      valid_q <= 1'b0;
    end else if (clear_i) begin
      data_q  <= data_q;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= valid_i;
    end else begin
      data_q  <= data_q;
      valid_q <= valid_q;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/data_in_window.sv
// Sliding operand window on the memory read-data path. Tap 0 is the live
// input word; taps 1..DEPTH-1 are the previously accepted words, oldest last.
// Build option DATA_IN_WINDOW_ZERO_INVALID_EN: invalid taps read as zero
// instead of showing stale register / input contents.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module data_in_window
  import data_in_window_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int DEPTH     = 3
) (
  input  logic                         clk,
  input  logic                         areset_n,
  input  logic [WORD_SIZE-1:0]         data_in,
  input  logic                         in_valid,
  input  logic                         advance,
  input  logic                         flush,
  output logic [DEPTH*WORD_SIZE-1:0]   taps,
  output logic [DEPTH-1:0]             tap_valid,
  output logic [$clog2(DEPTH)-1:0]     fill_count,
  output logic                         window_full
);

  localparam int CNT_W = fill_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Flush beats advance: a flushed cycle never captures data_in.
  logic stage_load;
  logic stage_clear;
  assign stage_clear = flush;
  assign stage_load  = advance & ~flush;

  logic [WORD_SIZE-1:0] st_data  [1:DEPTH-1];
  logic                 st_valid [1:DEPTH-1];

  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    logic [WORD_SIZE-1:0] stage_d_in;
    logic                 stage_v_in;
    if (k == 1) begin : g_first
      assign stage_d_in = data_in;
      assign stage_v_in = in_valid;
    end else begin : g_chain
      assign stage_d_in = st_data[k-1];
      assign stage_v_in = st_valid[k-1];
    end
    data_in_window_stage #(
      .WORD_SIZE (WORD_SIZE)
    ) u_stage (
      .clk      (clk),
      .areset_n (areset_n),
      .load_i   (stage_load),
      .clear_i  (stage_clear),
      .data_i   (stage_d_in),
      .valid_i  (stage_v_in),
      .data_o   (st_data[k]),
      .valid_o  (st_valid[k])
    );
  end

  // Fill counter, kept in step with the stage valid bits rather than recounted.
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic             oldest_valid;
  assign oldest_valid = st_valid[DEPTH-1];

  // Next fill count: flush empties, a shift adds the new valid and drops the oldest.
  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = CNT_ZERO;
    end else if (advance) begin
      if (in_valid && !oldest_valid) begin
        if (fill_q == CNT_MAX) begin
          fill_d = CNT_MAX;
        end else begin
          fill_d = fill_q + CNT_ONE;
        end
      end else if (!in_valid && oldest_valid) begin
        if (fill_q == CNT_ZERO) begin
          fill_d = CNT_ZERO;
        end else begin
          fill_d = fill_q - CNT_ONE;
        end
      end else begin
        fill_d = fill_q;
      end
    end else begin
      fill_d = fill_q;
    end
  end

  // Fill count register.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      fill_q <= CNT_ZERO;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_count = fill_q;

  // Tap assembly: tap 0 is the live input, tap k is stage k.
  always_comb begin
    taps      = {(DEPTH*WORD_SIZE){1'b0}};
    tap_valid = {DEPTH{1'b0}};
    tap_valid[0] = in_valid;
`ifdef DATA_IN_WINDOW_ZERO_INVALID_EN
    taps[0 +: WORD_SIZE] = in_valid ? data_in : {WORD_SIZE{1'b0}};
`else
    taps[0 +: WORD_SIZE] = data_in;
`endif
    for (int k = 1; k < DEPTH; k++) begin
      tap_valid[k] = st_valid[k];
`ifdef DATA_IN_WINDOW_ZERO_INVALID_EN
      taps[k*WORD_SIZE +: WORD_SIZE] = st_valid[k] ? st_data[k] : {WORD_SIZE{1'b0}};
`else
      taps[k*WORD_SIZE +: WORD_SIZE] = st_data[k];
`endif
    end
  end

  assign window_full = &tap_valid;

endmodule

// File: tb/tb_data_in_window.sv
// Directed self-checking bench for data_in_window (WORD_SIZE=8, DEPTH=3).
module tb_data_in_window;

  logic        clk;
  logic        areset_n;
  logic [7:0]  data_in;
  logic        in_valid;
  logic        advance;
  logic        flush;
  logic [23:0] taps;
  logic [2:0]  tap_valid;
  logic [1:0]  fill_count;
  logic        window_full;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DATA_IN_WINDOW_ZERO_INVALID_EN
  localparam bit ZMASK = 1'b1;
`else
  localparam bit ZMASK = 1'b0;
`endif

  data_in_window #(
    .WORD_SIZE (8),
    .DEPTH     (3)
  ) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .advance     (advance),
    .flush       (flush),
    .taps        (taps),
    .tap_valid   (tap_valid),
    .fill_count  (fill_count),
    .window_full (window_full)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Directed stimulus and checks.
  initial begin
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [1:0]  exp_fill;

    areset_n = 1'b0;
    data_in  = 8'h00;
    in_valid = 1'b0;
    advance  = 1'b0;
    flush    = 1'b0;
    tick();
    check_eq("rst_fill", 32'(fill_count), 32'd0);
    check_eq("rst_tap_valid", 32'(tap_valid), 32'd0);
    in_valid = 1'b1;
    #1;
    check_eq("rst_tap0_live", 32'(tap_valid), 32'h1);
    check_eq("rst_full", 32'(window_full), 32'd0);

    // Fill with 0x11, 0x22, 0x33.
    areset_n = 1'b1;
    advance  = 1'b1;
    data_in  = 8'h11;
    in_valid = 1'b1;
    tick();
    data_in = 8'h22;
    #1;
    check_eq("fill1_valid", 32'(tap_valid), 32'h3);
    check_eq("fill1_count", 32'(fill_count), 32'd1);
    check_eq("fill1_taps", 32'(taps), 32'h001122);
    tick();
    data_in = 8'h33;
    #1;
    check_eq("fill2_taps", 32'(taps), 32'h112233);
    check_eq("fill2_valid", 32'(tap_valid), 32'h7);
    check_eq("fill2_full", 32'(window_full), 32'd1);
    check_eq("fill2_count", 32'(fill_count), 32'd2);

    // Hold: drop advance before the edge, so 0x33 is never captured.
    advance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      data_in = 8'h50 + 8'(i);
      #1;
      check_eq("hold_taps", 32'(taps), {8'h00, 8'h11, 8'h22, data_in});
      check_eq("hold_count", 32'(fill_count), 32'd2);
      check_eq("hold_full", 32'(window_full), 32'd1);
    end

    // Flush together with advance: 0x44 must not be captured.
    flush   = 1'b1;
    advance = 1'b1;
    data_in = 8'h44;
    #1;
    check_eq("flush_tap0_live", 32'(taps), 32'h112244);
    tick();
    flush    = 1'b0;
    advance  = 1'b0;
    data_in  = 8'h66;
    in_valid = 1'b0;
    #1;
    check_eq("flush_valid", 32'(tap_valid), 32'd0);
    check_eq("flush_count", 32'(fill_count), 32'd0);
    check_eq("flush_taps", 32'(taps), ZMASK ? 32'h000000 : 32'h112266);
    tick();
    check_eq("flush_hold_count", 32'(fill_count), 32'd0);

    // Valid pattern 1,0,1 with bubble in the middle.
    advance  = 1'b1;
    data_in  = 8'hA1;
    in_valid = 1'b1;
    tick();
    data_in  = 8'h5A;
    in_valid = 1'b0;
    tick();
    data_in  = 8'hA3;
    in_valid = 1'b1;
    #1;
    check_eq("bubble_valid", 32'(tap_valid), 32'h5);
    check_eq("bubble_full", 32'(window_full), 32'd0);
    check_eq("bubble_count", 32'(fill_count), 32'd1);
    check_eq("bubble_taps", 32'(taps), ZMASK ? 32'hA100A3 : 32'hA15AA3);
    tick();
    advance  = 1'b0;
    in_valid = 1'b0;
    data_in  = 8'h00;
    #1;
    check_eq("bubble_shift_valid", 32'(tap_valid), 32'h2);
    check_eq("bubble_shift_count", 32'(fill_count), 32'd1);

    // Reset mid-fill overrides flush and advance.
    areset_n = 1'b0;
    flush    = 1'b1;
    advance  = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'h77;
    tick();
    areset_n = 1'b1;
    flush    = 1'b0;
    advance  = 1'b0;
    in_valid = 1'b0;
    data_in  = 8'h9C;
    #1;
    check_eq("midrst_valid", 32'(tap_valid), 32'd0);
    check_eq("midrst_count", 32'(fill_count), 32'd0);
    check_eq("midrst_taps", 32'(taps), ZMASK ? 32'h000000 : 32'h00009C);
    advance  = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'h88;
    tick();
    advance  = 1'b0;
    in_valid = 1'b0;
    data_in  = 8'h00;
    #1;
    check_eq("midrst_next_count", 32'(fill_count), 32'd1);
    check_eq("midrst_next_valid", 32'(tap_valid), 32'h2);
    check_eq("midrst_next_tap1", 32'(taps[15:8]), 32'h88);

    // Empty the window, then run a long continuous stream.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      advance  = 1'b1;
      in_valid = 1'b1;
      data_in  = 8'hC0 + 8'(i);
      #1;
      exp_fill = (i >= 2) ? 2'd2 : 2'(i);
      check_eq("stream_count", 32'(fill_count), 32'(exp_fill));
      check_eq("stream_full", 32'(window_full), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        b0 = 8'hC0 + 8'(i);
        b1 = b0 - 8'h01;
        b2 = b0 - 8'h02;
        check_eq("stream_taps", 32'(taps), {8'h00, b2, b1, b0});
      end else begin
        check_eq("stream_fill_valid", 32'(tap_valid[2]), 32'd0);
      end
      tick();
    end
    advance  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("stream_end_count", 32'(fill_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
